ram_bwe: RTL and testbench
==========================

// Module: ram_bwe
// PURPOSE
//  Register-based simple dual-port RAM, next generation of the common RAM: per-lane write
//  mask, read latency 1 or 2, selectable read-during-write policy and post-reset init sweep.
//  Used as line/row buffers by the filter and compression stages.
//  Replaces hand-written clear logic in users: init_done_o tells the user when the RAM is usable.
// PARAMETERS
//  SIZE      -1  number of words (any value >= 2; need not be a power of 2)
//  DATA_WD   -1  word width in bits; must be a multiple of LANE_WD
//  LANE_WD    8  write-mask granularity in bits
//  RD_LAT     1  read latency in cycles, 1 or 2
//  WR_FIRST   0  1: a same-address read returns the newly written data; 0: it returns the old data
//  INIT_EN    1  1: memory is swept to INIT_VAL after every reset
//  INIT_VAL   0  fill value of the sweep (DATA_WD bits)
//  derived: SIZE_WD = `LOG2(SIZE), MSK_WD = DATA_WD/LANE_WD
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rstn         in   1        asynchronous, active-low reset
//  wr_val_i     in   1        write strobe
//  wr_adr_i     in   SIZE_WD  write address
//  wr_dat_i     in   DATA_WD  write data
//  wr_msk_i     in   MSK_WD   lane enable; bit i writes bits [i*LANE_WD +: LANE_WD]
//  rd_val_i     in   1        read strobe
//  rd_adr_i     in   SIZE_WD  read address
//  rd_val_o     out  1        read data valid, exactly RD_LAT cycles after rd_val_i
//  rd_dat_o     out  DATA_WD  read data; holds its last value when rd_val_o=0
//  init_done_o  out  1        1 = RAM accepts reads/writes
// BEHAVIOUR
//  Reset values: rd_val_o=0, rd_dat_o=0, pipeline regs=0, FSM=INIT (INIT_EN=1) or RUN (INIT_EN=0),
//  init_done_o=!INIT_EN, sweep counter=0. Memory array itself has no reset.
//  FSM INIT: each cycle writes INIT_VAL (all lanes) to address cnt, cnt++; at cnt==SIZE-1 the
//   last write happens and FSM->RUN next edge. init_done_o rises exactly SIZE cycles after rstn release.
//  FSM RUN: terminal; left only by reset. Reset asserted mid-sweep or mid-read restarts from INIT
//   with cnt=0 and in-flight reads dropped (no rd_val_o pulse after reset release).
//  While init_done_o=0: wr_val_i and rd_val_i are ignored entirely (no write, no rd_val_o).
//  Write: on wr_val_i, only lanes with wr_msk_i[i]=1 change; wr_msk_i=0 is a no-op.
//  Address >= SIZE: write ignored; read completes normally with rd_dat_o=0.
//  Read RD_LAT=1: at edge with rd_val_i, rd_dat_o<=word, rd_val_o<=1.
//  Read RD_LAT=2: stage1 registers word + valid at read edge; stage2 copies to rd_dat_o/rd_val_o
//   next edge (stage2 data loads only when stage1 valid). Back-to-back reads give one word/cycle.
//  Collision (wr_val_i & rd_val_i, same in-range address, same cycle):
//   WR_FIRST=1 -> returned word = masked merge (wr_dat_i on enabled lanes, old data elsewhere);
//   WR_FIRST=0 -> returned word = old data. Array always receives the write.
//  A write in the cycle after a read (RD_LAT=2) never alters that read's data.
//  Different addresses in the same cycle are independent; full throughput both ports.
// TESTING
//  T1 INIT_EN=1,SIZE=10,INIT_VAL=8'hA5: release rstn, read all -> init_done_o high at cycle 10, all words 'hA5.
//  T2 DATA_WD=32: write 'h11223344 to adr 3, then wr_msk_i=4'b0101 data 'hAABBCCDD -> read adr 3 gives 'h11BB33DD.
//  T3 Collision adr 5 old 'h0, write 'hFFFF_FFFF full mask + read same cycle -> WR_FIRST=0 returns 0,
//     WR_FIRST=1 returns 'hFFFF_FFFF; following read returns 'hFFFF_FFFF in both.
//  T4 RD_LAT=2, reads adr 0,1,2 back-to-back -> rd_val_o high for 3 cycles starting 2 cycles later, data in order.
//  T5 SIZE=10: write adr 12 then read adr 12 -> rd_val_o pulses, rd_dat_o=0; adr 0..9 unchanged.
//  T6 Assert rstn at sweep cnt=4 and during a pending RD_LAT=2 read -> outputs 0 immediately, no stray
//     rd_val_o, sweep restarts, init_done_o rises SIZE cycles after release.

Source files
------------

// File: rtl/ram_bwe.sv
// Register-based simple dual-port RAM with per-lane write mask, 1- or 2-cycle read latency,
// selectable read-during-write policy and an optional post-reset fill sweep.
module ram_bwe #(
  parameter int                 SIZE     = 16,
  parameter int                 DATA_WD  = 32,
  parameter int                 LANE_WD  = 8,
  parameter int                 RD_LAT   = 1,
  parameter int                 WR_FIRST = 0,
  parameter int                 INIT_EN  = 1,
  parameter logic [DATA_WD-1:0] INIT_VAL = {DATA_WD{1'b0}},
  localparam int                SIZE_WD  = $clog2(SIZE),
  localparam int                MSK_WD   = DATA_WD / LANE_WD
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_val_i,
  input  logic [SIZE_WD-1:0] wr_adr_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  input  logic [MSK_WD-1:0]  wr_msk_i,
  input  logic               rd_val_i,
  input  logic [SIZE_WD-1:0] rd_adr_i,
  output logic               rd_val_o,
  output logic [DATA_WD-1:0] rd_dat_o,
  output logic               init_done_o
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam state_e             ST_RST   = (INIT_EN != 0) ? ST_INIT : ST_RUN;
  localparam logic               DONE_RST = (INIT_EN != 0) ? 1'b0 : 1'b1;
  localparam logic [SIZE_WD:0]   SIZE_L   = SIZE[SIZE_WD:0];
  localparam logic [SIZE_WD-1:0] CNT_LAST = SIZE_WD'(SIZE - 1);

  function automatic logic [DATA_WD-1:0] lane_merge(input logic [DATA_WD-1:0] old_dat,
                                                    input logic [DATA_WD-1:0] new_dat,
                                                    input logic [MSK_WD-1:0]  msk);
    logic [DATA_WD-1:0] res;
    res = old_dat;
    for (int i = 0; i < MSK_WD; i++) begin
      if (msk[i]) begin
        res[i*LANE_WD +: LANE_WD] = new_dat[i*LANE_WD +: LANE_WD];
      end else begin
        res[i*LANE_WD +: LANE_WD] = old_dat[i*LANE_WD +: LANE_WD];
      end
    end
    return res;
  endfunction

  logic [DATA_WD-1:0] mem_q [SIZE];

  state_e             state_q, state_d;
  logic [SIZE_WD-1:0] cnt_q, cnt_d;
  logic               init_done_q, init_done_d;
  logic               rd_val_q, rd_val_d;
  logic [DATA_WD-1:0] rd_dat_q, rd_dat_d;

  logic               wr_in_rng_s, rd_in_rng_s, wr_en_s, rd_en_s, wr_hit_s;
  logic               mem_we_s;
  logic [SIZE_WD-1:0] mem_wadr_s;
  logic [DATA_WD-1:0] mem_wdat_s, rd_word_s;

  // Sweep sequencing: INIT fills one word per cycle, RUN is terminal until reset.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_RUN;
          cnt_d       = {SIZE_WD{1'b0}};
          init_done_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + SIZE_WD'(1);
          init_done_d = 1'b0;
        end
      end
      ST_RUN:  init_done_d = 1'b1;
      default: begin
        state_d     = ST_RST;
        cnt_d       = {SIZE_WD{1'b0}};
        init_done_d = DONE_RST;
      end
    endcase
  end

  // User ports stay dead until the sweep completes; out-of-range addresses never touch the array.
  always_comb begin
    wr_in_rng_s = ({1'b0, wr_adr_i} < SIZE_L);
    rd_in_rng_s = ({1'b0, rd_adr_i} < SIZE_L);
    wr_en_s     = init_done_q & wr_val_i & wr_in_rng_s;
    rd_en_s     = init_done_q & rd_val_i;
    wr_hit_s    = wr_en_s & rd_in_rng_s & (wr_adr_i == rd_adr_i);
    if (state_q == ST_INIT) begin
      mem_we_s   = 1'b1;
      mem_wadr_s = cnt_q;
      mem_wdat_s = INIT_VAL;
    end else if (wr_en_s) begin
      mem_we_s   = 1'b1;
      mem_wadr_s = wr_adr_i;
      mem_wdat_s = lane_merge(mem_q[wr_adr_i], wr_dat_i, wr_msk_i);
    end else begin
      mem_we_s   = 1'b0;
      mem_wadr_s = wr_adr_i;
      mem_wdat_s = wr_dat_i;
    end
    if (!rd_in_rng_s) begin
      rd_word_s = {DATA_WD{1'b0}};
    end else if ((WR_FIRST != 0) && wr_hit_s) begin
      rd_word_s = mem_wdat_s;
    end else begin
      rd_word_s = mem_q[rd_adr_i];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic               s1_val_q, s1_val_d;
      logic [DATA_WD-1:0] s1_dat_q, s1_dat_d;

      // Stage 1 captures the word at the read edge so later writes cannot disturb it.
      always_comb begin
        s1_val_d = rd_en_s;
        rd_val_d = s1_val_q;
        if (rd_en_s) begin
          s1_dat_d = rd_word_s;
        end else begin
          s1_dat_d = s1_dat_q;
        end
        if (s1_val_q) begin
          rd_dat_d = s1_dat_q;
        end else begin
          rd_dat_d = rd_dat_q;
        end
      end

      // Stage 1 pipeline registers.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          s1_val_q <= 1'b0;
          s1_dat_q <= {DATA_WD{1'b0}};
        end else begin
          s1_val_q <= s1_val_d;
          s1_dat_q <= s1_dat_d;
        end
      end
    end else begin : g_lat1
      // Single-cycle read: output registers load directly from the array.
      always_comb begin
        rd_val_d = rd_en_s;
        if (rd_en_s) begin
          rd_dat_d = rd_word_s;
        end else begin
          rd_dat_d = rd_dat_q;
        end
      end
    end
  endgenerate

  // Control state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RST;
      cnt_q       <= {SIZE_WD{1'b0}};
      init_done_q <= DONE_RST;
      rd_val_q    <= 1'b0;
      rd_dat_q    <= {DATA_WD{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_val_q    <= rd_val_d;
      rd_dat_q    <= rd_dat_d;
    end
  end

  // Storage array, intentionally without reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_wadr_s] <= mem_wdat_s;
    end
  end

  assign rd_val_o    = rd_val_q;
  assign rd_dat_o    = rd_dat_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_ram_bwe.sv
// Directed bench: two ram_bwe instances (RD_LAT=1/WR_FIRST=0 and RD_LAT=2/WR_FIRST=1)
// share the same stimulus and are checked against hand-computed values.
module tb_ram_bwe;

  logic        clk;
  logic        rstn;
  logic        wr_val_i;
  logic [3:0]  wr_adr_i;
  logic [31:0] wr_dat_i;
  logic [3:0]  wr_msk_i;
  logic        rd_val_i;
  logic [3:0]  rd_adr_i;
  logic        a_rd_val, b_rd_val, a_init, b_init;
  logic [31:0] a_rd_dat, b_rd_dat;
  logic [31:0] exp_final [10];

  int checks = 0;
  int errors = 0;

  ram_bwe #(.SIZE(10), .DATA_WD(32), .LANE_WD(8), .RD_LAT(1), .WR_FIRST(0), .INIT_EN(1),
            .INIT_VAL(32'h0000_00A5)) dut_a (
    .clk(clk), .rstn(rstn), .wr_val_i(wr_val_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
    .wr_msk_i(wr_msk_i), .rd_val_i(rd_val_i), .rd_adr_i(rd_adr_i), .rd_val_o(a_rd_val),
    .rd_dat_o(a_rd_dat), .init_done_o(a_init));

  ram_bwe #(.SIZE(10), .DATA_WD(32), .LANE_WD(8), .RD_LAT(2), .WR_FIRST(1), .INIT_EN(1),
            .INIT_VAL(32'h0000_00A5)) dut_b (
    .clk(clk), .rstn(rstn), .wr_val_i(wr_val_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i),
    .wr_msk_i(wr_msk_i), .rd_val_i(rd_val_i), .rd_adr_i(rd_adr_i), .rd_val_o(b_rd_val),
    .rd_dat_o(b_rd_dat), .init_done_o(b_init));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a_val"}, 32'(a_rd_val), 32'd0);
    chk({tag, "_b_val"}, 32'(b_rd_val), 32'd0);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] msk);
    wr_val_i = 1'b1;
    wr_adr_i = adr;
    wr_dat_i = dat;
    wr_msk_i = msk;
    @(negedge clk);
    wr_val_i = 1'b0;
  endtask

  // Read (optionally with a same-address write in the same cycle); ea/eb per instance.
  task automatic rdw(input string tag, input logic [3:0] adr, input logic we,
                     input logic [31:0] wdat, input logic [3:0] wmsk,
                     input logic [31:0] ea, input logic [31:0] eb);
    rd_val_i = 1'b1;
    rd_adr_i = adr;
    wr_val_i = we;
    wr_adr_i = adr;
    wr_dat_i = wdat;
    wr_msk_i = wmsk;
    @(negedge clk);
    rd_val_i = 1'b0;
    wr_val_i = 1'b0;
    chk({tag, "_a_val"}, 32'(a_rd_val), 32'd1);
    chk({tag, "_a_dat"}, a_rd_dat, ea);
    chk({tag, "_b_early"}, 32'(b_rd_val), 32'd0);
    @(negedge clk);
    chk({tag, "_a_drop"}, 32'(a_rd_val), 32'd0);
    chk({tag, "_a_hold"}, a_rd_dat, ea);
    chk({tag, "_b_val"}, 32'(b_rd_val), 32'd1);
    chk({tag, "_b_dat"}, b_rd_dat, eb);
  endtask

  task automatic rd(input string tag, input logic [3:0] adr,
                    input logic [31:0] ea, input logic [31:0] eb);
    rdw(tag, adr, 1'b0, 32'h0, 4'h0, ea, eb);
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        wr_val_i = 1'b0;
        rd_val_i = 1'b0;
      end
      chk({tag, "_a_init"}, 32'(a_init), 32'(i >= 10));
      chk({tag, "_b_init"}, 32'(b_init), 32'(i >= 10));
      chk_quiet(tag);
    end
    @(negedge clk);
    chk_quiet({tag, "_tail"});
  endtask

  initial begin
    rstn     = 1'b0;
    wr_val_i = 1'b0;
    wr_adr_i = 4'd0;
    wr_dat_i = 32'h0;
    wr_msk_i = 4'h0;
    rd_val_i = 1'b0;
    rd_adr_i = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_a_dat", a_rd_dat, 32'h0);
    chk("rst_b_dat", b_rd_dat, 32'h0);
    chk("rst_a_init", 32'(a_init), 32'd0);
    chk("rst_b_init", 32'(b_init), 32'd0);
    chk_quiet("rst");

    // T1: sweep, with a write and read to adr 7 attempted throughout it (must be ignored)
    wr_val_i = 1'b1;
    wr_adr_i = 4'd7;
    wr_dat_i = 32'hDEAD_BEEF;
    wr_msk_i = 4'hF;
    rd_val_i = 1'b1;
    rd_adr_i = 4'd7;
    rstn     = 1'b1;
    sweep_check("t1");
    for (int a = 0; a < 10; a++) rd("t1_fill", 4'(a), 32'h0000_00A5, 32'h0000_00A5);

    // T2: lane mask merge, and an all-zero mask is a no-op
    wr(4'd3, 32'h1122_3344, 4'hF);
    wr(4'd3, 32'hAABB_CCDD, 4'b0101);
    rd("t2_mask", 4'd3, 32'h11BB_33DD, 32'h11BB_33DD);
    wr(4'd3, 32'h0000_0000, 4'h0);
    rd("t2_nomask", 4'd3, 32'h11BB_33DD, 32'h11BB_33DD);

    // T3: same-address collision, old-data vs write-first
    wr(4'd5, 32'h0, 4'hF);
    rdw("t3_col", 4'd5, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'hFFFF_FFFF);
    rd("t3_after", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rdw("t3_colmsk", 4'd6, 1'b1, 32'h1234_5678, 4'b0011, 32'h0000_00A5, 32'h0000_5678);

    // T4: back-to-back reads, one word per cycle on both latencies
    wr(4'd0, 32'h100, 4'hF);
    wr(4'd1, 32'h101, 4'hF);
    wr(4'd2, 32'h102, 4'hF);
    rd_val_i = 1'b1;
    rd_adr_i = 4'd0;
    @(negedge clk);
    rd_adr_i = 4'd1;
    chk("t4_c1_a_val", 32'(a_rd_val), 32'd1);
    chk("t4_c1_a_dat", a_rd_dat, 32'h100);
    chk("t4_c1_b_val", 32'(b_rd_val), 32'd0);
    @(negedge clk);
    rd_adr_i = 4'd2;
    chk("t4_c2_a_dat", a_rd_dat, 32'h101);
    chk("t4_c2_b_val", 32'(b_rd_val), 32'd1);
    chk("t4_c2_b_dat", b_rd_dat, 32'h100);
    @(negedge clk);
    rd_val_i = 1'b0;
    chk("t4_c3_a_dat", a_rd_dat, 32'h102);
    chk("t4_c3_b_val", 32'(b_rd_val), 32'd1);
    chk("t4_c3_b_dat", b_rd_dat, 32'h101);
    @(negedge clk);
    chk("t4_c4_a_val", 32'(a_rd_val), 32'd0);
    chk("t4_c4_b_val", 32'(b_rd_val), 32'd1);
    chk("t4_c4_b_dat", b_rd_dat, 32'h102);
    @(negedge clk);
    chk("t4_c5_b_val", 32'(b_rd_val), 32'd0);
    chk("t4_c5_b_hold", b_rd_dat, 32'h102);

    // T4b: a write in the cycle after a read does not alter that read
    rd_val_i = 1'b1;
    rd_adr_i = 4'd2;
    @(negedge clk);
    rd_val_i = 1'b0;
    wr_val_i = 1'b1;
    wr_adr_i = 4'd2;
    wr_dat_i = 32'h0000_BEEF;
    wr_msk_i = 4'hF;
    chk("t4w_a_dat", a_rd_dat, 32'h102);
    @(negedge clk);
    wr_val_i = 1'b0;
    chk("t4w_b_val", 32'(b_rd_val), 32'd1);
    chk("t4w_b_dat", b_rd_dat, 32'h102);
    rd("t4w_new", 4'd2, 32'h0000_BEEF, 32'h0000_BEEF);

    // T5: out-of-range write ignored, out-of-range read returns zero
    wr(4'd12, 32'h1212_1212, 4'hF);
    rd("t5_oor", 4'd12, 32'h0, 32'h0);
    exp_final[0] = 32'h100;        exp_final[1] = 32'h101;
    exp_final[2] = 32'h0000_BEEF;  exp_final[3] = 32'h11BB_33DD;
    exp_final[4] = 32'h0000_00A5;  exp_final[5] = 32'hFFFF_FFFF;
    exp_final[6] = 32'h0000_5678;  exp_final[7] = 32'h0000_00A5;
    exp_final[8] = 32'h0000_00A5;  exp_final[9] = 32'h0000_00A5;
    for (int a = 0; a < 10; a++) rd("t5_scan", 4'(a), exp_final[a], exp_final[a]);

    // T6: reset during a pending 2-cycle read, then again mid-sweep at cnt=4
    rd_val_i = 1'b1;
    rd_adr_i = 4'd1;
    @(negedge clk);
    rd_val_i = 1'b0;
    rstn     = 1'b0;
    #1;
    chk("t6_rst_a_dat", a_rd_dat, 32'h0);
    chk("t6_rst_b_dat", b_rd_dat, 32'h0);
    chk("t6_rst_a_init", 32'(a_init), 32'd0);
    chk_quiet("t6_rst");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t6_part_init", 32'(b_init), 32'd0);
      chk_quiet("t6_part");
    end
    rstn = 1'b0;
    #1;
    chk("t6_mid_b_init", 32'(b_init), 32'd0);
    chk_quiet("t6_mid");
    @(negedge clk);
    rstn = 1'b1;
    sweep_check("t6");
    rd("t6_refill", 4'd1, 32'h0000_00A5, 32'h0000_00A5);
    rd("t6_refill9", 4'd9, 32'h0000_00A5, 32'h0000_00A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
